idex_pipe_reg: RTL and testbench
================================

# idex_pipe_reg

ID/EX pipeline register with load-use hazard detection for the five-stage pipelined CPU. It captures decoded operands and control from the ID stage each cycle and drives the `EXin_*` inputs of the execute stage. When the instruction in EX is a load whose destination is read by the instruction in ID, it requests a one-cycle stall of IF/ID and inserts a bubble. It also squashes the instruction entering EX when a taken branch or jump resolved downstream asserts `Flush`.

## Interface
- No parameters. Widths are fixed to the 32-bit MIPS datapath.
- `Clk` input 1: rising-edge clock.
- `Reset` input 1: asynchronous, active-high reset.
- `Hold` input 1: global freeze (memory wait); register keeps its contents.
- `Flush` input 1: squash the instruction entering EX on this edge.
- `ID_PC4`, `ID_Jtarg`, `ID_busA`, `ID_busB` input 32 each: ID-stage data.
- `ID_Rs`, `ID_Rt`, `ID_Rd` input 5 each: register fields of the ID instruction.
- `ID_UsesRt` input 1: the ID instruction reads rt as a source (R-type, store, branch).
- `ID_func` input 6, `ID_immd` input 16, `ID_ALUop` input 3.
- `ID_RegWr`, `ID_ALUSrc`, `ID_RegDst`, `ID_MemtoReg`, `ID_MemWr`, `ID_Branch`, `ID_Jump`, `ID_ExtOp`, `ID_R_type` input 1 each.
- `EXin_*` output, same names and widths as the `ID_*` inputs except `ID_Rs` and `ID_UsesRt`: registered values delivered to EX.
- `EX_Valid` output 1: EX holds a real instruction (0 = bubble).
- `Stall` output 1: combinational; holds the PC and the IF/ID register.
- `Bubble_cnt`, `Flush_cnt` output 32 each: performance counters (see Configuration).

## Operation
- EX destination: `Rw_ex = EXin_RegDst ? EXin_Rd : EXin_Rt`.
- Hazard (combinational): asserted when all of the following hold:
  - `EX_Valid & EXin_MemtoReg & EXin_RegWr`;
  - `Rw_ex != 0`;
  - `Rw_ex == ID_Rs`, or (`ID_UsesRt` and `Rw_ex == ID_Rt`).
- `Stall = hazard & ~Flush & ~Hold`.
- Per-edge action, highest priority first:
  1. `Hold`: every register, `EX_Valid` and both counters keep their values.
  2. `Flush`: load a bubble; `Flush_cnt` increments.
  3. hazard: load a bubble; `Bubble_cnt` increments.
  4. otherwise: load all `ID_*` fields; `EX_Valid` <= 1.
- Bubble contents:
  - `EXin_RegWr`, `EXin_MemtoReg`, `EXin_MemWr`, `EXin_Branch` and `EXin_Jump` are forced to 0.
  - `EX_Valid` <= 0.
  - All other fields load their `ID_*` values; they are don't-care for the datapath but deterministic for the bench.
- A bubble has `EXin_MemtoReg = 0`, so the hazard clears on the cycle after insertion. Stall length is exactly one cycle per load-use pair.
- Back-to-back loads into the same register: each load independently produces one stall against its consumer.
- Writes to register $0 never cause a stall.

## Timing
- Latency: ID values appear on `EXin_*` one cycle after capture.
- `Stall` depends on `EXin_*` and the current `ID_*`, with no registered delay. It must settle within the same cycle.
- Reset, asynchronous and taking effect immediately, including mid-stall:
  - all `EXin_*` outputs 0;
  - `EX_Valid` = 0;
  - `Stall` = 0;
  - both counters 0.
- First edge after `Reset` deasserts performs a normal load; any hazard is evaluated against the cleared (bubble) state.
- `Flush` together with a hazard: the flush wins, `Stall` = 0, and only `Flush_cnt` increments.
- `Hold` together with anything else: nothing changes and `Stall` = 0.
- Counters wrap modulo 2^32 with no saturation.

## Configuration
- `IDEX_PERF_CNT_EN` defined: `Bubble_cnt` and `Flush_cnt` are implemented as described above.
- Not defined: both counters are tied to constant 0, no counter flops are synthesized, and the ports remain present.

## Test plan
- Reset mid-operation:
  - Stimulus: load `ID_RegWr=1`, `ID_busA=32'h1234`, then assert `Reset` between clock edges.
  - Required: all outputs 0 immediately; `EX_Valid=0`.
- Load-use on rs:
  - Stimulus: EX holds `lw` (RegDst=0, Rt=8, MemtoReg=1, RegWr=1); ID holds `add` with Rs=8.
  - Required: `Stall=1` for exactly one cycle; next cycle `EX_Valid=0` and `EXin_RegWr=0`; the cycle after, the `add` is loaded with `EX_Valid=1`; `Bubble_cnt=1`.
- rt gating:
  - Stimulus: same `lw` in EX, ID Rt=8, first with `ID_UsesRt=0`, then with `ID_UsesRt=1`.
  - Required: `Stall=0` in the first case, `Stall=1` in the second.
- $0 exemption:
  - Stimulus: `lw` to Rt=0 in EX, ID Rs=0.
  - Required: `Stall=0`; normal load on the next edge.
- Flush beats hazard:
  - Stimulus: hazard condition present with `Flush=1` on the same cycle.
  - Required: `Stall=0`; bubble loaded; `Flush_cnt=1`, `Bubble_cnt=0`.
- Hold beats everything:
  - Stimulus: `Hold=1` for 3 cycles while `ID_*` inputs change and `Flush=1`.
  - Required: `EXin_*`, `EX_Valid` and both counters unchanged; `Stall=0`.
  - Also with `IDEX_PERF_CNT_EN` undefined: both counters read 0 throughout.

Source files
------------

// File: rtl/idex_pipe_reg.sv
// ID/EX pipeline register with load-use stall, flush squash and hold freeze.
// Optional perf counters: define IDEX_PERF_CNT_EN to implement Bubble_cnt/Flush_cnt.
module idex_pipe_reg (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Hold,
    input  logic        Flush,
    input  logic [31:0] ID_PC4,
    input  logic [31:0] ID_Jtarg,
    input  logic [31:0] ID_busA,
    input  logic [31:0] ID_busB,
    input  logic [4:0]  ID_Rs,
    input  logic [4:0]  ID_Rt,
    input  logic [4:0]  ID_Rd,
    input  logic        ID_UsesRt,
    input  logic [5:0]  ID_func,
    input  logic [15:0] ID_immd,
    input  logic [2:0]  ID_ALUop,
    input  logic        ID_RegWr,
    input  logic        ID_ALUSrc,
    input  logic        ID_RegDst,
    input  logic        ID_MemtoReg,
    input  logic        ID_MemWr,
    input  logic        ID_Branch,
    input  logic        ID_Jump,
    input  logic        ID_ExtOp,
    input  logic        ID_R_type,
    output logic [31:0] EXin_PC4,
    output logic [31:0] EXin_Jtarg,
    output logic [31:0] EXin_busA,
    output logic [31:0] EXin_busB,
    output logic [4:0]  EXin_Rt,
    output logic [4:0]  EXin_Rd,
    output logic [5:0]  EXin_func,
    output logic [15:0] EXin_immd,
    output logic [2:0]  EXin_ALUop,
    output logic        EXin_RegWr,
    output logic        EXin_ALUSrc,
    output logic        EXin_RegDst,
    output logic        EXin_MemtoReg,
    output logic        EXin_MemWr,
    output logic        EXin_Branch,
    output logic        EXin_Jump,
    output logic        EXin_ExtOp,
    output logic        EXin_R_type,
    output logic        EX_Valid,
    output logic        Stall,
    output logic [31:0] Bubble_cnt,
    output logic [31:0] Flush_cnt
);

    typedef struct packed {
        logic [31:0] pc4;
        logic [31:0] jtarg;
        logic [31:0] busa;
        logic [31:0] busb;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [5:0]  func;
        logic [15:0] immd;
        logic [2:0]  aluop;
        logic        regwr;
        logic        alusrc;
        logic        regdst;
        logic        memtoreg;
        logic        memwr;
        logic        branch;
        logic        jump;
        logic        extop;
        logic        rtype;
    } ex_t;

    ex_t        id_s;
    ex_t        ex_d;
    ex_t        ex_q;
    logic       valid_d;
    logic       valid_q;
    logic [4:0] rw_ex;
    logic       hazard;

    assign id_s = '{
        pc4:      ID_PC4,
        jtarg:    ID_Jtarg,
        busa:     ID_busA,
        busb:     ID_busB,
        rt:       ID_Rt,
        rd:       ID_Rd,
        func:     ID_func,
        immd:     ID_immd,
        aluop:    ID_ALUop,
        regwr:    ID_RegWr,
        alusrc:   ID_ALUSrc,
        regdst:   ID_RegDst,
        memtoreg: ID_MemtoReg,
        memwr:    ID_MemWr,
        branch:   ID_Branch,
        jump:     ID_Jump,
        extop:    ID_ExtOp,
        rtype:    ID_R_type
    };

    assign rw_ex = ex_q.regdst ? ex_q.rd : ex_q.rt;

    always_comb begin
        hazard = 1'b0;
        if (valid_q && ex_q.memtoreg && ex_q.regwr && (rw_ex != 5'd0)) begin
            hazard = (rw_ex == ID_Rs) || (ID_UsesRt && (rw_ex == ID_Rt));
        end
    end

    assign Stall = hazard & ~Flush & ~Hold;

    always_comb begin
        ex_d    = ex_q;
        valid_d = valid_q;
        if (!Hold) begin
            ex_d    = id_s;
            valid_d = 1'b1;
            // Bubble keeps the data fields but kills every state-changing control
            if (Flush || hazard) begin
                ex_d.regwr    = 1'b0;
                ex_d.memtoreg = 1'b0;
                ex_d.memwr    = 1'b0;
                ex_d.branch   = 1'b0;
                ex_d.jump     = 1'b0;
                valid_d       = 1'b0;
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            ex_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            ex_q    <= ex_d;
            valid_q <= valid_d;
        end
    end

`ifdef IDEX_PERF_CNT_EN
    logic [31:0] bub_q;
    logic [31:0] bub_d;
    logic [31:0] fl_q;
    logic [31:0] fl_d;

    always_comb begin
        bub_d = bub_q;
        fl_d  = fl_q;
        if (!Hold) begin
            if (Flush) begin
                fl_d = fl_q + 32'd1;
            end else if (hazard) begin
                bub_d = bub_q + 32'd1;
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            bub_q <= '0;
            fl_q  <= '0;
        end else begin
            bub_q <= bub_d;
            fl_q  <= fl_d;
        end
    end

    assign Bubble_cnt = bub_q;
    assign Flush_cnt  = fl_q;
`else
    assign Bubble_cnt = '0;
    assign Flush_cnt  = '0;
`endif

    assign EXin_PC4      = ex_q.pc4;
    assign EXin_Jtarg    = ex_q.jtarg;
    assign EXin_busA     = ex_q.busa;
    assign EXin_busB     = ex_q.busb;
    assign EXin_Rt       = ex_q.rt;
    assign EXin_Rd       = ex_q.rd;
    assign EXin_func     = ex_q.func;
    assign EXin_immd     = ex_q.immd;
    assign EXin_ALUop    = ex_q.aluop;
    assign EXin_RegWr    = ex_q.regwr;
    assign EXin_ALUSrc   = ex_q.alusrc;
    assign EXin_RegDst   = ex_q.regdst;
    assign EXin_MemtoReg = ex_q.memtoreg;
    assign EXin_MemWr    = ex_q.memwr;
    assign EXin_Branch   = ex_q.branch;
    assign EXin_Jump     = ex_q.jump;
    assign EXin_ExtOp    = ex_q.extop;
    assign EXin_R_type   = ex_q.rtype;
    assign EX_Valid      = valid_q;

endmodule

// File: tb/tb_idex_pipe_reg.sv
// Directed scoreboard bench for idex_pipe_reg (counters checked when IDEX_PERF_CNT_EN is defined).
module tb_idex_pipe_reg;

    typedef struct packed {
        logic [31:0] pc4;
        logic [31:0] jtarg;
        logic [31:0] busa;
        logic [31:0] busb;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [5:0]  func;
        logic [15:0] immd;
        logic [2:0]  aluop;
        logic        regwr;
        logic        alusrc;
        logic        regdst;
        logic        memtoreg;
        logic        memwr;
        logic        branch;
        logic        jump;
        logic        extop;
        logic        rtype;
        logic        valid;
        logic [31:0] bub;
        logic [31:0] fl;
    } obs_t;

    localparam int M_LOAD  = 0;
    localparam int M_FLUSH = 1;
    localparam int M_HAZ   = 2;
    localparam int M_HOLD  = 3;

    logic        Clk;
    logic        Reset;
    logic        Hold;
    logic        Flush;
    logic [31:0] ID_PC4, ID_Jtarg, ID_busA, ID_busB;
    logic [4:0]  ID_Rs, ID_Rt, ID_Rd;
    logic        ID_UsesRt;
    logic [5:0]  ID_func;
    logic [15:0] ID_immd;
    logic [2:0]  ID_ALUop;
    logic        ID_RegWr, ID_ALUSrc, ID_RegDst, ID_MemtoReg, ID_MemWr;
    logic        ID_Branch, ID_Jump, ID_ExtOp, ID_R_type;
    logic [31:0] EXin_PC4, EXin_Jtarg, EXin_busA, EXin_busB;
    logic [4:0]  EXin_Rt, EXin_Rd;
    logic [5:0]  EXin_func;
    logic [15:0] EXin_immd;
    logic [2:0]  EXin_ALUop;
    logic        EXin_RegWr, EXin_ALUSrc, EXin_RegDst, EXin_MemtoReg, EXin_MemWr;
    logic        EXin_Branch, EXin_Jump, EXin_ExtOp, EXin_R_type;
    logic        EX_Valid;
    logic        Stall;
    logic [31:0] Bubble_cnt, Flush_cnt;

    int   checks = 0;
    int   errors = 0;
    obs_t cur;
    obs_t obs;
    obs_t sb[$];

    idex_pipe_reg dut (
        .Clk(Clk), .Reset(Reset), .Hold(Hold), .Flush(Flush),
        .ID_PC4(ID_PC4), .ID_Jtarg(ID_Jtarg), .ID_busA(ID_busA), .ID_busB(ID_busB),
        .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_Rd(ID_Rd), .ID_UsesRt(ID_UsesRt),
        .ID_func(ID_func), .ID_immd(ID_immd), .ID_ALUop(ID_ALUop),
        .ID_RegWr(ID_RegWr), .ID_ALUSrc(ID_ALUSrc), .ID_RegDst(ID_RegDst),
        .ID_MemtoReg(ID_MemtoReg), .ID_MemWr(ID_MemWr), .ID_Branch(ID_Branch),
        .ID_Jump(ID_Jump), .ID_ExtOp(ID_ExtOp), .ID_R_type(ID_R_type),
        .EXin_PC4(EXin_PC4), .EXin_Jtarg(EXin_Jtarg), .EXin_busA(EXin_busA),
        .EXin_busB(EXin_busB), .EXin_Rt(EXin_Rt), .EXin_Rd(EXin_Rd),
        .EXin_func(EXin_func), .EXin_immd(EXin_immd), .EXin_ALUop(EXin_ALUop),
        .EXin_RegWr(EXin_RegWr), .EXin_ALUSrc(EXin_ALUSrc), .EXin_RegDst(EXin_RegDst),
        .EXin_MemtoReg(EXin_MemtoReg), .EXin_MemWr(EXin_MemWr),
        .EXin_Branch(EXin_Branch), .EXin_Jump(EXin_Jump), .EXin_ExtOp(EXin_ExtOp),
        .EXin_R_type(EXin_R_type), .EX_Valid(EX_Valid), .Stall(Stall),
        .Bubble_cnt(Bubble_cnt), .Flush_cnt(Flush_cnt)
    );

    assign obs = {EXin_PC4, EXin_Jtarg, EXin_busA, EXin_busB, EXin_Rt, EXin_Rd,
                  EXin_func, EXin_immd, EXin_ALUop, EXin_RegWr, EXin_ALUSrc,
                  EXin_RegDst, EXin_MemtoReg, EXin_MemWr, EXin_Branch, EXin_Jump,
                  EXin_ExtOp, EXin_R_type, EX_Valid, Bubble_cnt, Flush_cnt};

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk_stall(input logic exp, input string tag);
        checks++;
        assert (Stall === exp) else begin
            errors++;
            $error("FAIL %s: Stall=%b expected %b", tag, Stall, exp);
        end
    endtask

    task automatic chk_state(input obs_t exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive an instruction; data fields are randomized
    task automatic set_instr(input logic [4:0] rs, input logic [4:0] rt,
                             input logic [4:0] rd, input logic uses_rt,
                             input logic regdst, input logic memtoreg,
                             input logic regwr);
        ID_Rs       = rs;
        ID_Rt       = rt;
        ID_Rd       = rd;
        ID_UsesRt   = uses_rt;
        ID_RegDst   = regdst;
        ID_MemtoReg = memtoreg;
        ID_RegWr    = regwr;
        ID_PC4      = $urandom;
        ID_Jtarg    = $urandom;
        ID_busA     = $urandom;
        ID_busB     = $urandom;
        ID_func     = 6'($urandom);
        ID_immd     = 16'($urandom);
        ID_ALUop    = 3'($urandom);
        ID_ALUSrc   = 1'($urandom);
        ID_MemWr    = 1'($urandom);
        ID_Branch   = 1'($urandom);
        ID_Jump     = 1'($urandom);
        ID_ExtOp    = 1'($urandom);
        ID_R_type   = 1'($urandom);
    endtask

    // Check Stall, push expected next state, clock, pop and compare
    task automatic step(input int mode, input logic exp_stall, input string tag);
        obs_t nxt;
        obs_t e;
        #1;
        chk_stall(exp_stall, tag);
        nxt = cur;
        if (mode != M_HOLD) begin
            nxt.pc4      = ID_PC4;
            nxt.jtarg    = ID_Jtarg;
            nxt.busa     = ID_busA;
            nxt.busb     = ID_busB;
            nxt.rt       = ID_Rt;
            nxt.rd       = ID_Rd;
            nxt.func     = ID_func;
            nxt.immd     = ID_immd;
            nxt.aluop    = ID_ALUop;
            nxt.regwr    = ID_RegWr;
            nxt.alusrc   = ID_ALUSrc;
            nxt.regdst   = ID_RegDst;
            nxt.memtoreg = ID_MemtoReg;
            nxt.memwr    = ID_MemWr;
            nxt.branch   = ID_Branch;
            nxt.jump     = ID_Jump;
            nxt.extop    = ID_ExtOp;
            nxt.rtype    = ID_R_type;
            nxt.valid    = 1'b1;
            if (mode == M_FLUSH || mode == M_HAZ) begin
                nxt.regwr    = 1'b0;
                nxt.memtoreg = 1'b0;
                nxt.memwr    = 1'b0;
                nxt.branch   = 1'b0;
                nxt.jump     = 1'b0;
                nxt.valid    = 1'b0;
            end
`ifdef IDEX_PERF_CNT_EN
            if (mode == M_FLUSH) nxt.fl = cur.fl + 32'd1;
            if (mode == M_HAZ) nxt.bub = cur.bub + 32'd1;
`endif
        end
        sb.push_back(nxt);
        cur = nxt;
        @(posedge Clk);
        #1;
        checks++;
        assert (sb.size() > 0) else begin
            errors++;
            $error("FAIL %s: scoreboard empty got %0d expected 1", tag, sb.size());
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk_state(e, tag);
        end
    endtask

    task automatic do_reset_now(input string tag);
        Reset = 1'b1;
        #1;
        cur = '0;
        sb.delete();
        chk_state(cur, tag);
        chk_stall(1'b0, tag);
    endtask

    initial begin
        Reset = 1'b1;
        Hold  = 1'b0;
        Flush = 1'b0;
        set_instr(5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1);
        cur = '0;
        @(posedge Clk);
        #1;
        chk_state(cur, "reset_state");
        chk_stall(1'b0, "reset_stall");
        @(negedge Clk);
        Reset = 1'b0;

        // first load after reset, then mid-cycle reset
        set_instr(5'd4, 5'd5, 5'd6, 1'b1, 1'b1, 1'b0, 1'b1);
        ID_busA = 32'h1234;
        step(M_LOAD, 1'b0, "first_load");
        #3;
        do_reset_now("reset_midop");
        @(negedge Clk);
        Reset = 1'b0;

        // load-use on rs
        set_instr(5'd3, 5'd8, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        step(M_LOAD, 1'b0, "lw_rs_load");
        set_instr(5'd8, 5'd9, 5'd10, 1'b1, 1'b1, 1'b0, 1'b1);
        step(M_HAZ, 1'b1, "rs_hazard");
        step(M_LOAD, 1'b0, "rs_after_bubble");

        // rt gated by UsesRt
        set_instr(5'd3, 5'd8, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        step(M_LOAD, 1'b0, "lw_rt0_load");
        set_instr(5'd2, 5'd8, 5'd11, 1'b0, 1'b1, 1'b0, 1'b1);
        step(M_LOAD, 1'b0, "rt_unused");
        set_instr(5'd3, 5'd8, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        step(M_LOAD, 1'b0, "lw_rt1_load");
        set_instr(5'd2, 5'd8, 5'd11, 1'b1, 1'b1, 1'b0, 1'b1);
        step(M_HAZ, 1'b1, "rt_used");
        step(M_LOAD, 1'b0, "rt_after_bubble");

        // $0 never stalls
        set_instr(5'd3, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        step(M_LOAD, 1'b0, "lw_r0_load");
        set_instr(5'd0, 5'd0, 5'd12, 1'b1, 1'b1, 1'b0, 1'b1);
        step(M_LOAD, 1'b0, "r0_exempt");

        // flush beats hazard
        set_instr(5'd3, 5'd8, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        step(M_LOAD, 1'b0, "lw_fl_load");
        set_instr(5'd8, 5'd9, 5'd10, 1'b1, 1'b1, 1'b0, 1'b1);
        Flush = 1'b1;
        step(M_FLUSH, 1'b0, "flush_wins");
        Flush = 1'b0;
        step(M_LOAD, 1'b0, "after_flush");

        // hold beats everything, with a live hazard underneath
        set_instr(5'd3, 5'd8, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        step(M_LOAD, 1'b0, "lw_hold_load");
        Hold  = 1'b1;
        Flush = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_instr(5'd8, 5'(13 + i), 5'd10, 1'b1, 1'b1, 1'b0, 1'b1);
            step(M_HOLD, 1'b0, "hold_freeze");
        end
        Hold  = 1'b0;
        Flush = 1'b0;
        set_instr(5'd8, 5'd9, 5'd10, 1'b1, 1'b1, 1'b0, 1'b1);
        step(M_HAZ, 1'b1, "hazard_after_hold");
        step(M_LOAD, 1'b0, "load_after_hold");

        // back-to-back loads into the same register
        set_instr(5'd3, 5'd8, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        step(M_LOAD, 1'b0, "b2b_lw1");
        set_instr(5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        step(M_HAZ, 1'b1, "b2b_stall1");
        step(M_LOAD, 1'b0, "b2b_lw2");
        set_instr(5'd8, 5'd9, 5'd10, 1'b1, 1'b1, 1'b0, 1'b1);
        step(M_HAZ, 1'b1, "b2b_stall2");
        step(M_LOAD, 1'b0, "b2b_consumer");

        // reset in the middle of a stall
        set_instr(5'd3, 5'd7, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        step(M_LOAD, 1'b0, "lw_rst_load");
        set_instr(5'd7, 5'd9, 5'd10, 1'b1, 1'b1, 1'b0, 1'b1);
        #2;
        chk_stall(1'b1, "pre_reset_stall");
        do_reset_now("reset_midstall");
        @(negedge Clk);
        Reset = 1'b0;
        step(M_LOAD, 1'b0, "post_reset_load");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
